// File: rtl/ysyx_22050710_sram_pkg.sv
// ysyx_22050710_sram_pkg
// Shared encodings for the SRAM-like responder:
//   SIZE_*        transfer size field values (1/2/4/8 bytes)
//   OP_*          request direction values
//   resp_entry_t  one delay-line slot {valid, op, data}
package ysyx_22050710_sram_pkg;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;
  localparam logic [1:0] SIZE_D = 2'd3;

  localparam logic OP_RD = 1'b0;
  localparam logic OP_WR = 1'b1;

  // Widest data bus a response entry can carry; narrower buses use the low bits.
  localparam int RESP_DATA_WD = 64;

  typedef struct packed {
    logic                    valid;
    logic                    op;
    logic [RESP_DATA_WD-1:0] data;
  } resp_entry_t;

endpackage

// File: rtl/ysyx_22050710_resp_delay_line.sv
// ysyx_22050710_resp_delay_line
// Fixed-latency shift register of response entries. An entry is loaded into
// stage 0 on the accept edge, picks up the memory read word on its way into
// stage 1, and is reported from the last stage. With LATENCY = 1 the memory
// word is forwarded combinationally while stage 0 is the last stage.
// Ports:
//   i_clk, i_rst_n   clock, synchronous active-low clear of every stage
//   i_load, i_load_op  new entry (valid, op) entering stage 0
//   i_mem_rdata      backing memory read word (valid the cycle after access)
//   o_last_valid     last stage holds a response this cycle
//   o_last_data      response data; zero for writes and empty slots
module ysyx_22050710_resp_delay_line
  import ysyx_22050710_sram_pkg::*;
#(
  parameter int LATENCY = 2,
  parameter int DATA_WD = 64
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_load,
  input  logic               i_load_op,
  input  logic [DATA_WD-1:0] i_mem_rdata,
  output logic               o_last_valid,
  output logic [DATA_WD-1:0] o_last_data
);

  resp_entry_t stage_reg  [LATENCY];
  resp_entry_t stage_next [LATENCY];

  generate
    for (genvar gi = 0; gi < LATENCY; gi++) begin : g_stage
      if (gi == 0) begin : g_head
        assign stage_next[gi] = '{valid: i_load, op: i_load_op, data: '0};
      end else if (gi == 1) begin : g_capture
        // Memory answers one cycle after the access, i.e. while the entry
        // sits in stage 0; only reads keep it so writes report zero.
        assign stage_next[gi] = '{
          valid: stage_reg[0].valid,
          op:    stage_reg[0].op,
          data:  (stage_reg[0].valid && stage_reg[0].op == OP_RD)
                 ? RESP_DATA_WD'(i_mem_rdata) : '0
        };
      end else begin : g_shift
        assign stage_next[gi] = stage_reg[gi-1];
      end
    end
  endgenerate

  always_ff @(posedge i_clk) begin
    for (int i = 0; i < LATENCY; i++) begin
      if (!i_rst_n) begin
        stage_reg[i] <= '0;
      end else begin
        stage_reg[i] <= stage_next[i];
      end
    end
  end

  generate
    if (LATENCY == 1) begin : g_lat1
      assign o_last_valid = stage_reg[0].valid;
      assign o_last_data  = (stage_reg[0].valid && stage_reg[0].op == OP_RD)
                            ? i_mem_rdata : '0;
    end else begin : g_latn
      assign o_last_valid = stage_reg[LATENCY-1].valid;
      assign o_last_data  = stage_reg[LATENCY-1].data[DATA_WD-1:0];
    end
  endgenerate

endmodule

// File: rtl/ysyx_22050710_sram_responder.sv
// ysyx_22050710_sram_responder
// Responder end of the SRAM-like req/addr_ok/data_ok bus. Accepted requests
// access a single-cycle synchronous memory in the accept cycle and answer
// in order exactly LATENCY cycles later; at most QDEPTH are outstanding.
// Optional macro YSYX_22050710_SRAM_RESP_STALL_EN adds LFSR-driven random
// addr_ok backpressure (about one cycle in four).
// Ports:
//   i_clk, i_rst_n          clock, synchronous active-low reset
//   i_req/i_op/i_size/i_addr/i_wstrb/i_wdata   request channel
//   o_addr_ok               request accepted when i_req is also high
//   o_data_ok, o_rdata      in-order response, rdata zero for writes
//   o_mem_*                 backing memory port, i_mem_rdata one cycle later
module ysyx_22050710_sram_responder
  import ysyx_22050710_sram_pkg::*;
#(
  parameter int SRAM_ADDR_WD  = 64,
  parameter int SRAM_DATA_WD  = 64,
  parameter int SRAM_WMASK_WD = 8,
  parameter int LATENCY       = 2,
  parameter int QDEPTH        = 2
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_req,
  input  logic                     i_op,
  input  logic [1:0]               i_size,
  input  logic [SRAM_ADDR_WD-1:0]  i_addr,
  input  logic [SRAM_WMASK_WD-1:0] i_wstrb,
  input  logic [SRAM_DATA_WD-1:0]  i_wdata,
  output logic                     o_addr_ok,
  output logic                     o_data_ok,
  output logic [SRAM_DATA_WD-1:0]  o_rdata,
  output logic                     o_mem_en,
  output logic                     o_mem_we,
  output logic [SRAM_ADDR_WD-1:0]  o_mem_addr,
  output logic [SRAM_WMASK_WD-1:0] o_mem_wmask,
  output logic [SRAM_DATA_WD-1:0]  o_mem_wdata,
  input  logic [SRAM_DATA_WD-1:0]  i_mem_rdata
);

  localparam int CNT_WD = $clog2(QDEPTH + 1);
  localparam int OFF_WD = $clog2(SRAM_WMASK_WD);

  logic [CNT_WD-1:0] cnt_reg;
  logic [CNT_WD-1:0] cnt_next;
  logic              stall;
  logic              fire;
  logic              data_ok;
  logic              unused_bits;

  // Size and byte offset do not matter: the whole aligned word is accessed
  // and the initiator's strobes / lane selection do the rest.
  assign unused_bits = ^{i_size, i_addr[OFF_WD-1:0]};

`ifdef YSYX_22050710_SRAM_RESP_STALL_EN
  logic [15:0] lfsr_reg;
  logic [15:0] lfsr_next;

  // Fibonacci taps 16,14,13,11.
  assign lfsr_next = {lfsr_reg[14:0],
                      lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10]};
  assign stall     = (lfsr_reg[1:0] == 2'b00);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      lfsr_reg <= 16'hACE1;
    end else begin
      lfsr_reg <= lfsr_next;
    end
  end
`else
  assign stall = 1'b0;
`endif

  // The slot freed by this cycle's response may be reused in the same cycle,
  // so a full queue still accepts while its oldest entry completes. Both
  // terms are registered state, so there is no req -> addr_ok path.
  assign o_addr_ok = !stall && ((cnt_reg < CNT_WD'(QDEPTH)) || data_ok);
  assign fire      = i_req && o_addr_ok && i_rst_n;

  assign o_mem_en    = fire;
  assign o_mem_we    = fire && (i_op == OP_WR);
  assign o_mem_addr  = {i_addr[SRAM_ADDR_WD-1:OFF_WD], {OFF_WD{1'b0}}};
  assign o_mem_wmask = i_wstrb & {SRAM_WMASK_WD{i_op}};
  assign o_mem_wdata = i_wdata;

  always_comb begin
    cnt_next = cnt_reg;
    if (fire && !data_ok) begin
      cnt_next = cnt_reg + 1'b1;
    end else if (!fire && data_ok) begin
      cnt_next = cnt_reg - 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

  ysyx_22050710_resp_delay_line #(
    .LATENCY (LATENCY),
    .DATA_WD (SRAM_DATA_WD)
  ) u_delay_line (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_load       (fire),
    .i_load_op    (i_op),
    .i_mem_rdata  (i_mem_rdata),
    .o_last_valid (data_ok),
    .o_last_data  (o_rdata)
  );

  assign o_data_ok = data_ok;

endmodule

// File: tb/tb_ysyx_22050710_sram_responder.sv
module tb_ysyx_22050710_sram_responder;

  typedef struct {
    int          due;
    logic [63:0] data;
  } pend_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req, op;
  logic [1:0]  size;
  logic [63:0] addr, wdata;
  logic [7:0]  wstrb;
  int          sel;

  logic        req_w       [2];
  logic        addr_ok_w   [2];
  logic        data_ok_w   [2];
  logic [63:0] rdata_w     [2];
  logic        mem_en_w    [2];
  logic        mem_we_w    [2];
  logic [63:0] mem_addr_w  [2];
  logic [7:0]  mem_wmask_w [2];
  logic [63:0] mem_wdata_w [2];
  logic [63:0] mem_rdata_w [2];

  int lat_of [2] = '{2, 1};
  int qd_of  [2] = '{2, 1};

  pend_t       pend[$];
  bit [63:0]   ref_mem [bit [63:0]];
  bit [63:0]   env_mem [bit [63:0]];
  int          now;
  int          vectors;
  int          miscompares;
  int          open_cycles;
  int          stall_cycles;

  logic        exp_addr_ok, exp_data_ok, exp_fire;
  logic [63:0] exp_rdata;
  logic        obs_addr_ok, obs_data_ok, obs_mem_en, obs_mem_we;
  logic [63:0] obs_rdata, obs_mem_addr;
  logic [7:0]  obs_mem_wmask;

  always #5 clk = ~clk;

  assign req_w[0] = req && (sel == 0);
  assign req_w[1] = req && (sel == 1);

  ysyx_22050710_sram_responder #(.LATENCY(2), .QDEPTH(2)) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req_w[0]), .i_op(op), .i_size(size),
    .i_addr(addr), .i_wstrb(wstrb), .i_wdata(wdata),
    .o_addr_ok(addr_ok_w[0]), .o_data_ok(data_ok_w[0]), .o_rdata(rdata_w[0]),
    .o_mem_en(mem_en_w[0]), .o_mem_we(mem_we_w[0]), .o_mem_addr(mem_addr_w[0]),
    .o_mem_wmask(mem_wmask_w[0]), .o_mem_wdata(mem_wdata_w[0]),
    .i_mem_rdata(mem_rdata_w[0])
  );

  ysyx_22050710_sram_responder #(.LATENCY(1), .QDEPTH(1)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req_w[1]), .i_op(op), .i_size(size),
    .i_addr(addr), .i_wstrb(wstrb), .i_wdata(wdata),
    .o_addr_ok(addr_ok_w[1]), .o_data_ok(data_ok_w[1]), .o_rdata(rdata_w[1]),
    .o_mem_en(mem_en_w[1]), .o_mem_we(mem_we_w[1]), .o_mem_addr(mem_addr_w[1]),
    .o_mem_wmask(mem_wmask_w[1]), .o_mem_wdata(mem_wdata_w[1]),
    .i_mem_rdata(mem_rdata_w[1])
  );

  // Backing memory seen by the DUTs: driven purely by their memory ports.
  always @(posedge clk) begin
    bit [63:0] k;
    bit [63:0] w;
    for (int d = 0; d < 2; d++) begin
      if (mem_en_w[d] === 1'b1) begin
        k = mem_addr_w[d] >> 3;
        w = env_mem.exists(k) ? env_mem[k] : 64'd0;
        if (mem_we_w[d]) begin
          for (int b = 0; b < 8; b++)
            if (mem_wmask_w[d][b]) w[8*b +: 8] = mem_wdata_w[d][8*b +: 8];
          env_mem[k] = w;
        end else begin
          mem_rdata_w[d] <= w;
        end
      end
    end
  end

  task automatic preload(input bit [63:0] a, input bit [63:0] d);
    env_mem[a >> 3] = d;
    ref_mem[a >> 3] = d;
  endtask

  // Apply one cycle of stimulus, sample the selected DUT and work out what
  // it should show from the outstanding-request list.
  task automatic drive(input logic r, input logic o, input logic [63:0] a,
                       input logic [7:0] s, input logic [63:0] w);
    int busy;
    req = r; op = o; addr = a; wstrb = s; wdata = w; size = 2'd3;
    #1;
    obs_addr_ok   = addr_ok_w[sel];
    obs_data_ok   = data_ok_w[sel];
    obs_rdata     = rdata_w[sel];
    obs_mem_en    = mem_en_w[sel];
    obs_mem_we    = mem_we_w[sel];
    obs_mem_addr  = mem_addr_w[sel];
    obs_mem_wmask = mem_wmask_w[sel];
    busy = 0;
    foreach (pend[i]) if (pend[i].due > now) busy++;
    exp_data_ok = (pend.size() > 0) && (pend[0].due == now);
    exp_rdata   = exp_data_ok ? pend[0].data : 64'd0;
`ifdef YSYX_22050710_SRAM_RESP_STALL_EN
    exp_addr_ok = obs_addr_ok && (busy < qd_of[sel]);
    if (busy < qd_of[sel]) begin
      open_cycles++;
      if (!obs_addr_ok) stall_cycles++;
    end
`else
    exp_addr_ok = (busy < qd_of[sel]);
`endif
    exp_fire = r && exp_addr_ok && rst_n;
  endtask

  // Retire / record transactions in the reference, then move one cycle on.
  task automatic advance();
    bit [63:0] k;
    bit [63:0] wd;
    if (exp_data_ok) begin
      $display("resp t=%0d dut%0d rdata=%h", now, sel, exp_rdata);
      void'(pend.pop_front());
    end
    if (exp_fire) begin
      k  = addr >> 3;
      wd = ref_mem.exists(k) ? ref_mem[k] : 64'd0;
      if (op) begin
        for (int b = 0; b < 8; b++) if (wstrb[b]) wd[8*b +: 8] = wdata[8*b +: 8];
        ref_mem[k] = wd;
        pend.push_back('{due: now + lat_of[sel], data: 64'd0});
      end else begin
        pend.push_back('{due: now + lat_of[sel], data: wd});
      end
    end
    if (!rst_n) pend.delete();
    @(posedge clk);
    @(negedge clk);
    now++;
  endtask

  task automatic test_reset();
    for (int d = 0; d < 2; d++) begin
      sel = d; rst_n = 1'b0;
      drive(1'b1, 1'b0, 64'h40, 8'h00, 64'h0);
      vectors++;
      if (obs_mem_en !== 1'b0) begin
        miscompares++; $display("FAIL reset_mem_en dut%0d: got %b want 0", d, obs_mem_en);
      end
      advance();
      rst_n = 1'b1;
      drive(1'b0, 1'b0, 64'h0, 8'h00, 64'h0);
      vectors++;
      if ({obs_addr_ok, obs_data_ok, obs_mem_en} !== {exp_addr_ok, 2'b00}) begin
        miscompares++;
        $display("FAIL reset_flags dut%0d: got ok=%b dok=%b en=%b want ok=%b dok=0 en=0",
                 d, obs_addr_ok, obs_data_ok, obs_mem_en, exp_addr_ok);
      end
      vectors++;
      if (obs_rdata !== 64'd0) begin
        miscompares++; $display("FAIL reset_rdata dut%0d: got %h want 0", d, obs_rdata);
      end
      advance();
    end
  endtask

  task automatic test_single_read();
    bit fired = 0;
    int fire_cyc = -1;
    sel = 0;
    preload(64'h8000_0000, 64'h1122_3344_5566_7788);
    for (int c = 0; c < 10; c++) begin
      drive(!fired, 1'b0, 64'h8000_0000, 8'h00, 64'h0);
      vectors++;
      if (obs_addr_ok !== exp_addr_ok || obs_mem_en !== exp_fire) begin
        miscompares++;
        $display("FAIL single_accept t=%0d: got ok=%b en=%b want ok=%b en=%b",
                 now, obs_addr_ok, obs_mem_en, exp_addr_ok, exp_fire);
      end
      if (exp_fire) begin
        fire_cyc = now;
        vectors++;
        if (obs_mem_addr !== 64'h8000_0000 || obs_mem_we !== 1'b0) begin
          miscompares++;
          $display("FAIL single_mem t=%0d: got addr=%h we=%b want 80000000 we=0",
                   now, obs_mem_addr, obs_mem_we);
        end
      end
      vectors++;
      if (obs_data_ok !== exp_data_ok || obs_rdata !== exp_rdata) begin
        miscompares++;
        $display("FAIL single_resp t=%0d: got dok=%b rdata=%h want dok=%b rdata=%h",
                 now, obs_data_ok, obs_rdata, exp_data_ok, exp_rdata);
      end
      if (fire_cyc >= 0 && now == fire_cyc + 2) begin
        vectors++;
        if (obs_data_ok !== 1'b1 || obs_rdata !== 64'h1122_3344_5566_7788) begin
          miscompares++;
          $display("FAIL single_latency t=%0d: got dok=%b rdata=%h want 1 1122334455667788",
                   now, obs_data_ok, obs_rdata);
        end
      end
      if (exp_fire) fired = 1;
      advance();
    end
  endtask

  task automatic test_back_to_back();
    int idx = 0;
    sel = 0;
    for (int i = 0; i < 3; i++) preload(64'(i * 8), {$urandom, $urandom});
    for (int c = 0; c < 10; c++) begin
      drive(idx < 3, 1'b0, 64'(idx * 8), 8'h00, 64'h0);
      vectors++;
      if (obs_addr_ok !== exp_addr_ok) begin
        miscompares++;
        $display("FAIL b2b_addr_ok t=%0d: got %b want %b", now, obs_addr_ok, exp_addr_ok);
      end
      vectors++;
      if (obs_data_ok !== exp_data_ok || obs_rdata !== exp_rdata) begin
        miscompares++;
        $display("FAIL b2b_resp t=%0d: got dok=%b rdata=%h want dok=%b rdata=%h",
                 now, obs_data_ok, obs_rdata, exp_data_ok, exp_rdata);
      end
      if (exp_fire) idx++;
      advance();
    end
  endtask

  task automatic test_write_mask();
    int idx = 0;
    sel = 0;
    preload(64'h100, 64'hA5A5_A5A5_5A5A_5A5A);
    for (int c = 0; c < 10; c++) begin
      drive(idx < 2, idx == 0, 64'h100, 8'h0F, 64'hDEAD_BEEF_CAFE_F00D);
      if (exp_fire && idx == 0) begin
        vectors++;
        if (obs_mem_we !== 1'b1 || obs_mem_wmask !== 8'h0F || obs_mem_addr !== 64'h100) begin
          miscompares++;
          $display("FAIL wr_mem t=%0d: got we=%b mask=%h addr=%h want 1 0f 100",
                   now, obs_mem_we, obs_mem_wmask, obs_mem_addr);
        end
      end
      if (exp_fire && idx == 1) begin
        vectors++;
        if (obs_mem_we !== 1'b0 || obs_mem_wmask !== 8'h00) begin
          miscompares++;
          $display("FAIL rd_mem t=%0d: got we=%b mask=%h want 0 00", now, obs_mem_we, obs_mem_wmask);
        end
      end
      vectors++;
      if (obs_data_ok !== exp_data_ok || obs_rdata !== exp_rdata) begin
        miscompares++;
        $display("FAIL wr_resp t=%0d: got dok=%b rdata=%h want dok=%b rdata=%h",
                 now, obs_data_ok, obs_rdata, exp_data_ok, exp_rdata);
      end
      if (exp_data_ok && exp_rdata != 64'd0) begin
        vectors++;
        if (obs_rdata !== 64'hA5A5_A5A5_CAFE_F00D) begin
          miscompares++;
          $display("FAIL wr_merge t=%0d: got %h want a5a5a5a5cafef00d", now, obs_rdata);
        end
      end
      if (exp_fire) idx++;
      advance();
    end
  endtask

  task automatic test_reset_midflight();
    int  idx  = 0;
    bit  done = 0;
    sel = 0;
    preload(64'h200, 64'h0123_4567_89AB_CDEF);
    preload(64'h208, 64'hFEDC_BA98_7654_3210);
    for (int c = 0; c < 12; c++) begin
      rst_n = !(idx == 2 && !done);
      drive(idx < 2, 1'b0, 64'h200 + 64'(idx * 8), 8'h00, 64'h0);
      vectors++;
      if (obs_data_ok !== exp_data_ok || obs_rdata !== exp_rdata) begin
        miscompares++;
        $display("FAIL rstmid_resp t=%0d: got dok=%b rdata=%h want dok=%b rdata=%h",
                 now, obs_data_ok, obs_rdata, exp_data_ok, exp_rdata);
      end
      if (done) begin
        vectors++;
        if (obs_data_ok !== 1'b0 || obs_addr_ok !== exp_addr_ok) begin
          miscompares++;
          $display("FAIL rstmid_after t=%0d: got dok=%b ok=%b want dok=0 ok=%b",
                   now, obs_data_ok, obs_addr_ok, exp_addr_ok);
        end
      end
      if (!rst_n) done = 1;
      if (exp_fire) idx++;
      advance();
    end
    rst_n = 1'b1;
  endtask

  task automatic test_random(input int dut, input int cycles, input bit reads_only);
    logic        r, o;
    logic [63:0] a;
    sel = dut;
    for (int i = 0; i < 16; i++) preload(64'h1000 + 64'(i * 8), {$urandom, $urandom});
    for (int c = 0; c < cycles + 4; c++) begin
      r = (c < cycles) && (reads_only || $urandom_range(0, 3) != 0);
      o = !reads_only && $urandom_range(0, 2) == 0;
      a = 64'h1000 + 64'($urandom_range(0, 127));
      drive(r, o, a, 8'($urandom), {$urandom, $urandom});
      vectors++;
      if (obs_addr_ok !== exp_addr_ok || obs_mem_en !== exp_fire) begin
        miscompares++;
        $display("FAIL rnd%0d_accept t=%0d: got ok=%b en=%b want ok=%b en=%b",
                 dut, now, obs_addr_ok, obs_mem_en, exp_addr_ok, exp_fire);
      end
      if (exp_fire) begin
        vectors++;
        if (obs_mem_addr !== (a & ~64'h7) || obs_mem_we !== o ||
            obs_mem_wmask !== (o ? wstrb : 8'h00)) begin
          miscompares++;
          $display("FAIL rnd%0d_mem t=%0d: got addr=%h we=%b mask=%h want addr=%h we=%b mask=%h",
                   dut, now, obs_mem_addr, obs_mem_we, obs_mem_wmask,
                   a & ~64'h7, o, o ? wstrb : 8'h00);
        end
      end
      vectors++;
      if (obs_data_ok !== exp_data_ok || obs_rdata !== exp_rdata) begin
        miscompares++;
        $display("FAIL rnd%0d_resp t=%0d: got dok=%b rdata=%h want dok=%b rdata=%h",
                 dut, now, obs_data_ok, obs_rdata, exp_data_ok, exp_rdata);
      end
      advance();
    end
  endtask

`ifdef YSYX_22050710_SRAM_RESP_STALL_EN
  task automatic test_stall_fraction();
    int pct;
    open_cycles = 0;
    stall_cycles = 0;
    test_random(0, 1000, 1'b1);
    pct = (stall_cycles * 100) / (open_cycles > 0 ? open_cycles : 1);
    vectors++;
    if (pct < 15 || pct > 35) begin
      miscompares++;
      $display("FAIL stall_fraction: got %0d%% (%0d/%0d) want 15..35%%",
               pct, stall_cycles, open_cycles);
    end
  endtask
`endif

  initial begin
    rst_n = 1'b0; req = 1'b0; op = 1'b0; size = 2'd0;
    addr = '0; wstrb = '0; wdata = '0; sel = 0; now = 0;
    vectors = 0; miscompares = 0; open_cycles = 0; stall_cycles = 0;
    mem_rdata_w[0] = '0; mem_rdata_w[1] = '0;
    repeat (2) @(negedge clk);
    test_reset();
    test_single_read();
    test_back_to_back();
    test_write_mask();
    test_reset_midflight();
    test_random(0, 300, 1'b0);
    test_random(1, 40, 1'b1);
    test_random(1, 200, 1'b0);
`ifdef YSYX_22050710_SRAM_RESP_STALL_EN
    test_stall_fraction();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
